// File: rtl/sys_master_arbiter_pkg.sv
// Shared types for the system-master arbiter: FSM state encodings and requester count.
package sys_master_arbiter_pkg;

   localparam int NUM_SYS_MASTERS = 2;

   typedef enum logic [1:0] {W_IDLE, W_ADDR, W_DATA, W_RESP} wr_state_e;
   typedef enum logic [1:0] {R_IDLE, R_ADDR, R_DATA} rd_state_e;

endpackage

// File: rtl/sys_master_arbiter_rr.sv
// 2-way round-robin grant; combinational grant, registered pointer that flips to the
// other requester after every grant so simultaneous requests alternate.
module sys_arb_rr
   import sys_master_arbiter_pkg::*;
(
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       arb_en,
   input  logic [NUM_SYS_MASTERS-1:0] req,
   output logic                       gnt_vld,
   output logic                       gnt_idx
);

   logic ptr;

   always_comb begin
      gnt_vld = arb_en && (req != '0);
      if (req[0] && req[1]) gnt_idx = ptr;
      else                  gnt_idx = req[1];
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)       ptr <= 1'b0;
      else if (gnt_vld) ptr <= ~gnt_idx;
   end

endmodule

// File: rtl/sys_master_arbiter.sv
// 2-to-1 AXI4 arbiter, independent write/read round-robin, one outstanding transaction
// per direction. Optional grant counters when SYS_ARB_STATS_EN is defined.
module sys_master_arbiter
   import sys_master_arbiter_pkg::*;
#(
   parameter int ADDR_WIDTH  = 32,
   parameter int DATA_WIDTH  = 32,
   parameter int ID_WIDTH    = 2
`ifdef SYS_ARB_STATS_EN
  ,parameter int STATS_WIDTH = 32
`endif
)(
   input  logic                    clk_i,
   input  logic                    rstn_i,
   // requester 0
   input  logic [ID_WIDTH-1:0]     s0_axi_awid, s0_axi_arid,
   input  logic [ADDR_WIDTH-1:0]   s0_axi_awaddr, s0_axi_araddr,
   input  logic [7:0]              s0_axi_awlen, s0_axi_arlen,
   input  logic [2:0]              s0_axi_awsize, s0_axi_arsize, s0_axi_awprot, s0_axi_arprot,
   input  logic [1:0]              s0_axi_awburst, s0_axi_arburst,
   input  logic                    s0_axi_awlock, s0_axi_arlock,
   input  logic [3:0]              s0_axi_awcache, s0_axi_arcache, s0_axi_awqos, s0_axi_arqos,
   input  logic [3:0]              s0_axi_awregion, s0_axi_arregion,
   input  logic                    s0_axi_awvalid, s0_axi_arvalid,
   output logic                    s0_axi_awready, s0_axi_arready,
   input  logic [DATA_WIDTH-1:0]   s0_axi_wdata,
   input  logic [DATA_WIDTH/8-1:0] s0_axi_wstrb,
   input  logic                    s0_axi_wlast, s0_axi_wvalid,
   output logic                    s0_axi_wready,
   output logic [ID_WIDTH-1:0]     s0_axi_bid, s0_axi_rid,
   output logic [1:0]              s0_axi_bresp, s0_axi_rresp,
   output logic                    s0_axi_bvalid,
   input  logic                    s0_axi_bready,
   output logic [DATA_WIDTH-1:0]   s0_axi_rdata,
   output logic                    s0_axi_rlast, s0_axi_rvalid,
   input  logic                    s0_axi_rready,
   // requester 1
   input  logic [ID_WIDTH-1:0]     s1_axi_awid, s1_axi_arid,
   input  logic [ADDR_WIDTH-1:0]   s1_axi_awaddr, s1_axi_araddr,
   input  logic [7:0]              s1_axi_awlen, s1_axi_arlen,
   input  logic [2:0]              s1_axi_awsize, s1_axi_arsize, s1_axi_awprot, s1_axi_arprot,
   input  logic [1:0]              s1_axi_awburst, s1_axi_arburst,
   input  logic                    s1_axi_awlock, s1_axi_arlock,
   input  logic [3:0]              s1_axi_awcache, s1_axi_arcache, s1_axi_awqos, s1_axi_arqos,
   input  logic [3:0]              s1_axi_awregion, s1_axi_arregion,
   input  logic                    s1_axi_awvalid, s1_axi_arvalid,
   output logic                    s1_axi_awready, s1_axi_arready,
   input  logic [DATA_WIDTH-1:0]   s1_axi_wdata,
   input  logic [DATA_WIDTH/8-1:0] s1_axi_wstrb,
   input  logic                    s1_axi_wlast, s1_axi_wvalid,
   output logic                    s1_axi_wready,
   output logic [ID_WIDTH-1:0]     s1_axi_bid, s1_axi_rid,
   output logic [1:0]              s1_axi_bresp, s1_axi_rresp,
   output logic                    s1_axi_bvalid,
   input  logic                    s1_axi_bready,
   output logic [DATA_WIDTH-1:0]   s1_axi_rdata,
   output logic                    s1_axi_rlast, s1_axi_rvalid,
   input  logic                    s1_axi_rready,
   // crossbar side
   output logic [ID_WIDTH-1:0]     m_axi_awid, m_axi_arid,
   output logic [ADDR_WIDTH-1:0]   m_axi_awaddr, m_axi_araddr,
   output logic [7:0]              m_axi_awlen, m_axi_arlen,
   output logic [2:0]              m_axi_awsize, m_axi_arsize, m_axi_awprot, m_axi_arprot,
   output logic [1:0]              m_axi_awburst, m_axi_arburst,
   output logic                    m_axi_awlock, m_axi_arlock,
   output logic [3:0]              m_axi_awcache, m_axi_arcache, m_axi_awqos, m_axi_arqos,
   output logic [3:0]              m_axi_awregion, m_axi_arregion,
   output logic                    m_axi_awvalid, m_axi_arvalid,
   input  logic                    m_axi_awready, m_axi_arready,
   output logic [DATA_WIDTH-1:0]   m_axi_wdata,
   output logic [DATA_WIDTH/8-1:0] m_axi_wstrb,
   output logic                    m_axi_wlast, m_axi_wvalid,
   input  logic                    m_axi_wready,
   input  logic [ID_WIDTH-1:0]     m_axi_bid, m_axi_rid,
   input  logic [1:0]              m_axi_bresp, m_axi_rresp,
   input  logic                    m_axi_bvalid,
   output logic                    m_axi_bready,
   input  logic [DATA_WIDTH-1:0]   m_axi_rdata,
   input  logic                    m_axi_rlast, m_axi_rvalid,
   output logic                    m_axi_rready,
   // status
   output logic                    wr_owner_o,
   output logic                    rd_owner_o,
   output logic                    wr_busy_o,
   output logic                    rd_busy_o
`ifdef SYS_ARB_STATS_EN
  ,output logic [STATS_WIDTH-1:0]  wr_grants0_o,
   output logic [STATS_WIDTH-1:0]  wr_grants1_o,
   output logic [STATS_WIDTH-1:0]  rd_grants0_o,
   output logic [STATS_WIDTH-1:0]  rd_grants1_o
`endif
);

   wr_state_e wr_state;
   rd_state_e rd_state;
   logic      wr_owner, rd_owner;
   logic      wr_gnt_vld, wr_gnt_idx, rd_gnt_vld, rd_gnt_idx;
   logic      in_w_addr, in_w_data, in_w_resp, in_r_addr, in_r_data;

   assign in_w_addr = (wr_state == W_ADDR);
   assign in_w_data = (wr_state == W_DATA);
   assign in_w_resp = (wr_state == W_RESP);
   assign in_r_addr = (rd_state == R_ADDR);
   assign in_r_data = (rd_state == R_DATA);

   sys_arb_rr u_wr_rr (
      .clk(clk_i), .rst_n(rstn_i), .arb_en(wr_state == W_IDLE),
      .req({s1_axi_awvalid, s0_axi_awvalid}), .gnt_vld(wr_gnt_vld), .gnt_idx(wr_gnt_idx)
   );

   sys_arb_rr u_rd_rr (
      .clk(clk_i), .rst_n(rstn_i), .arb_en(rd_state == R_IDLE),
      .req({s1_axi_arvalid, s0_axi_arvalid}), .gnt_vld(rd_gnt_vld), .gnt_idx(rd_gnt_idx)
   );

   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         wr_state <= W_IDLE;
         wr_owner <= 1'b0;
      end else begin
         case (wr_state)
            W_IDLE: if (wr_gnt_vld) begin
               wr_owner <= wr_gnt_idx;
               wr_state <= W_ADDR;
            end
            W_ADDR:  if (m_axi_awvalid && m_axi_awready) wr_state <= W_DATA;
            W_DATA:  if (m_axi_wvalid && m_axi_wready && m_axi_wlast) wr_state <= W_RESP;
            W_RESP:  if (m_axi_bvalid && m_axi_bready) wr_state <= W_IDLE;
            default: wr_state <= W_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         rd_state <= R_IDLE;
         rd_owner <= 1'b0;
      end else begin
         case (rd_state)
            R_IDLE: if (rd_gnt_vld) begin
               rd_owner <= rd_gnt_idx;
               rd_state <= R_ADDR;
            end
            R_ADDR:  if (m_axi_arvalid && m_axi_arready) rd_state <= R_DATA;
            R_DATA:  if (m_axi_rvalid && m_axi_rready && m_axi_rlast) rd_state <= R_IDLE;
            default: rd_state <= R_IDLE;
         endcase
      end
   end

   assign wr_owner_o = wr_owner;
   assign rd_owner_o = rd_owner;
   assign wr_busy_o  = (wr_state != W_IDLE);
   assign rd_busy_o  = (rd_state != R_IDLE);

   // Payload always follows the owner; only the valids/readies are gated by state.
   assign m_axi_awid     = wr_owner ? s1_axi_awid     : s0_axi_awid;
   assign m_axi_awaddr   = wr_owner ? s1_axi_awaddr   : s0_axi_awaddr;
   assign m_axi_awlen    = wr_owner ? s1_axi_awlen    : s0_axi_awlen;
   assign m_axi_awsize   = wr_owner ? s1_axi_awsize   : s0_axi_awsize;
   assign m_axi_awburst  = wr_owner ? s1_axi_awburst  : s0_axi_awburst;
   assign m_axi_awlock   = wr_owner ? s1_axi_awlock   : s0_axi_awlock;
   assign m_axi_awcache  = wr_owner ? s1_axi_awcache  : s0_axi_awcache;
   assign m_axi_awprot   = wr_owner ? s1_axi_awprot   : s0_axi_awprot;
   assign m_axi_awqos    = wr_owner ? s1_axi_awqos    : s0_axi_awqos;
   assign m_axi_awregion = wr_owner ? s1_axi_awregion : s0_axi_awregion;
   assign m_axi_awvalid  = in_w_addr && (wr_owner ? s1_axi_awvalid : s0_axi_awvalid);
   assign s0_axi_awready = in_w_addr && !wr_owner && m_axi_awready;
   assign s1_axi_awready = in_w_addr &&  wr_owner && m_axi_awready;

   assign m_axi_wdata    = wr_owner ? s1_axi_wdata : s0_axi_wdata;
   assign m_axi_wstrb    = wr_owner ? s1_axi_wstrb : s0_axi_wstrb;
   assign m_axi_wlast    = wr_owner ? s1_axi_wlast : s0_axi_wlast;
   assign m_axi_wvalid   = in_w_data && (wr_owner ? s1_axi_wvalid : s0_axi_wvalid);
   assign s0_axi_wready  = in_w_data && !wr_owner && m_axi_wready;
   assign s1_axi_wready  = in_w_data &&  wr_owner && m_axi_wready;

   assign s0_axi_bid     = m_axi_bid;
   assign s1_axi_bid     = m_axi_bid;
   assign s0_axi_bresp   = m_axi_bresp;
   assign s1_axi_bresp   = m_axi_bresp;
   assign s0_axi_bvalid  = in_w_resp && !wr_owner && m_axi_bvalid;
   assign s1_axi_bvalid  = in_w_resp &&  wr_owner && m_axi_bvalid;
   assign m_axi_bready   = in_w_resp && (wr_owner ? s1_axi_bready : s0_axi_bready);

   assign m_axi_arid     = rd_owner ? s1_axi_arid     : s0_axi_arid;
   assign m_axi_araddr   = rd_owner ? s1_axi_araddr   : s0_axi_araddr;
   assign m_axi_arlen    = rd_owner ? s1_axi_arlen    : s0_axi_arlen;
   assign m_axi_arsize   = rd_owner ? s1_axi_arsize   : s0_axi_arsize;
   assign m_axi_arburst  = rd_owner ? s1_axi_arburst  : s0_axi_arburst;
   assign m_axi_arlock   = rd_owner ? s1_axi_arlock   : s0_axi_arlock;
   assign m_axi_arcache  = rd_owner ? s1_axi_arcache  : s0_axi_arcache;
   assign m_axi_arprot   = rd_owner ? s1_axi_arprot   : s0_axi_arprot;
   assign m_axi_arqos    = rd_owner ? s1_axi_arqos    : s0_axi_arqos;
   assign m_axi_arregion = rd_owner ? s1_axi_arregion : s0_axi_arregion;
   assign m_axi_arvalid  = in_r_addr && (rd_owner ? s1_axi_arvalid : s0_axi_arvalid);
   assign s0_axi_arready = in_r_addr && !rd_owner && m_axi_arready;
   assign s1_axi_arready = in_r_addr &&  rd_owner && m_axi_arready;

   assign s0_axi_rid     = m_axi_rid;
   assign s1_axi_rid     = m_axi_rid;
   assign s0_axi_rdata   = m_axi_rdata;
   assign s1_axi_rdata   = m_axi_rdata;
   assign s0_axi_rresp   = m_axi_rresp;
   assign s1_axi_rresp   = m_axi_rresp;
   assign s0_axi_rlast   = m_axi_rlast;
   assign s1_axi_rlast   = m_axi_rlast;
   assign s0_axi_rvalid  = in_r_data && !rd_owner && m_axi_rvalid;
   assign s1_axi_rvalid  = in_r_data &&  rd_owner && m_axi_rvalid;
   assign m_axi_rready   = in_r_data && (rd_owner ? s1_axi_rready : s0_axi_rready);

`ifdef SYS_ARB_STATS_EN
   localparam logic [STATS_WIDTH-1:0] STATS_ONE = STATS_WIDTH'(1);

   // Saturating grant counters; they stop at all-ones rather than wrapping.
   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         wr_grants0_o <= '0;
         wr_grants1_o <= '0;
         rd_grants0_o <= '0;
         rd_grants1_o <= '0;
      end else begin
         if (wr_gnt_vld && !wr_gnt_idx && (wr_grants0_o != '1)) wr_grants0_o <= wr_grants0_o + STATS_ONE;
         if (wr_gnt_vld &&  wr_gnt_idx && (wr_grants1_o != '1)) wr_grants1_o <= wr_grants1_o + STATS_ONE;
         if (rd_gnt_vld && !rd_gnt_idx && (rd_grants0_o != '1)) rd_grants0_o <= rd_grants0_o + STATS_ONE;
         if (rd_gnt_vld &&  rd_gnt_idx && (rd_grants1_o != '1)) rd_grants1_o <= rd_grants1_o + STATS_ONE;
      end
   end
`endif

endmodule

// File: tb/tb_sys_master_arbiter.sv
// Directed bench for sys_master_arbiter; the crossbar side is an always-ready slave that
// answers B/R immediately (OKAY, single-beat reads).
module tb_sys_master_arbiter;

   logic clk_i = 1'b0;
   logic rstn_i;
   always #5 clk_i = ~clk_i;

   logic [1:0]  s0_axi_awid, s0_axi_arid, s1_axi_awid, s1_axi_arid, m_axi_awid, m_axi_arid;
   logic [31:0] s0_axi_awaddr, s0_axi_araddr, s1_axi_awaddr, s1_axi_araddr, m_axi_awaddr, m_axi_araddr;
   logic [7:0]  s0_axi_awlen, s0_axi_arlen, s1_axi_awlen, s1_axi_arlen, m_axi_awlen, m_axi_arlen;
   logic [2:0]  s0_axi_awsize, s0_axi_arsize, s1_axi_awsize, s1_axi_arsize, m_axi_awsize, m_axi_arsize;
   logic [2:0]  s0_axi_awprot, s0_axi_arprot, s1_axi_awprot, s1_axi_arprot, m_axi_awprot, m_axi_arprot;
   logic [1:0]  s0_axi_awburst, s0_axi_arburst, s1_axi_awburst, s1_axi_arburst, m_axi_awburst, m_axi_arburst;
   logic        s0_axi_awlock, s0_axi_arlock, s1_axi_awlock, s1_axi_arlock, m_axi_awlock, m_axi_arlock;
   logic [3:0]  s0_axi_awcache, s0_axi_arcache, s1_axi_awcache, s1_axi_arcache, m_axi_awcache, m_axi_arcache;
   logic [3:0]  s0_axi_awqos, s0_axi_arqos, s1_axi_awqos, s1_axi_arqos, m_axi_awqos, m_axi_arqos;
   logic [3:0]  s0_axi_awregion, s0_axi_arregion, s1_axi_awregion, s1_axi_arregion, m_axi_awregion, m_axi_arregion;
   logic        s0_axi_awvalid, s0_axi_arvalid, s1_axi_awvalid, s1_axi_arvalid, m_axi_awvalid, m_axi_arvalid;
   logic        s0_axi_awready, s0_axi_arready, s1_axi_awready, s1_axi_arready, m_axi_awready, m_axi_arready;
   logic [31:0] s0_axi_wdata, s1_axi_wdata, m_axi_wdata;
   logic [3:0]  s0_axi_wstrb, s1_axi_wstrb, m_axi_wstrb;
   logic        s0_axi_wlast, s1_axi_wlast, m_axi_wlast, s0_axi_wvalid, s1_axi_wvalid, m_axi_wvalid;
   logic        s0_axi_wready, s1_axi_wready, m_axi_wready;
   logic [1:0]  s0_axi_bid, s1_axi_bid, m_axi_bid, s0_axi_rid, s1_axi_rid, m_axi_rid;
   logic [1:0]  s0_axi_bresp, s1_axi_bresp, m_axi_bresp, s0_axi_rresp, s1_axi_rresp, m_axi_rresp;
   logic        s0_axi_bvalid, s1_axi_bvalid, m_axi_bvalid, s0_axi_bready, s1_axi_bready, m_axi_bready;
   logic [31:0] s0_axi_rdata, s1_axi_rdata, m_axi_rdata;
   logic        s0_axi_rlast, s1_axi_rlast, m_axi_rlast, s0_axi_rvalid, s1_axi_rvalid, m_axi_rvalid;
   logic        s0_axi_rready, s1_axi_rready, m_axi_rready;
   logic        wr_owner_o, rd_owner_o, wr_busy_o, rd_busy_o;
`ifdef SYS_ARB_STATS_EN
   logic [31:0] wr_grants0_o, wr_grants1_o, rd_grants0_o, rd_grants1_o;
`endif

   sys_master_arbiter dut (
      .clk_i(clk_i), .rstn_i(rstn_i),
      .s0_axi_awid(s0_axi_awid), .s0_axi_arid(s0_axi_arid), .s0_axi_awaddr(s0_axi_awaddr), .s0_axi_araddr(s0_axi_araddr),
      .s0_axi_awlen(s0_axi_awlen), .s0_axi_arlen(s0_axi_arlen), .s0_axi_awsize(s0_axi_awsize), .s0_axi_arsize(s0_axi_arsize),
      .s0_axi_awprot(s0_axi_awprot), .s0_axi_arprot(s0_axi_arprot), .s0_axi_awburst(s0_axi_awburst), .s0_axi_arburst(s0_axi_arburst),
      .s0_axi_awlock(s0_axi_awlock), .s0_axi_arlock(s0_axi_arlock), .s0_axi_awcache(s0_axi_awcache), .s0_axi_arcache(s0_axi_arcache),
      .s0_axi_awqos(s0_axi_awqos), .s0_axi_arqos(s0_axi_arqos), .s0_axi_awregion(s0_axi_awregion), .s0_axi_arregion(s0_axi_arregion),
      .s0_axi_awvalid(s0_axi_awvalid), .s0_axi_arvalid(s0_axi_arvalid), .s0_axi_awready(s0_axi_awready), .s0_axi_arready(s0_axi_arready),
      .s0_axi_wdata(s0_axi_wdata), .s0_axi_wstrb(s0_axi_wstrb), .s0_axi_wlast(s0_axi_wlast), .s0_axi_wvalid(s0_axi_wvalid),
      .s0_axi_wready(s0_axi_wready), .s0_axi_bid(s0_axi_bid), .s0_axi_rid(s0_axi_rid), .s0_axi_bresp(s0_axi_bresp),
      .s0_axi_rresp(s0_axi_rresp), .s0_axi_bvalid(s0_axi_bvalid), .s0_axi_bready(s0_axi_bready), .s0_axi_rdata(s0_axi_rdata),
      .s0_axi_rlast(s0_axi_rlast), .s0_axi_rvalid(s0_axi_rvalid), .s0_axi_rready(s0_axi_rready),
      .s1_axi_awid(s1_axi_awid), .s1_axi_arid(s1_axi_arid), .s1_axi_awaddr(s1_axi_awaddr), .s1_axi_araddr(s1_axi_araddr),
      .s1_axi_awlen(s1_axi_awlen), .s1_axi_arlen(s1_axi_arlen), .s1_axi_awsize(s1_axi_awsize), .s1_axi_arsize(s1_axi_arsize),
      .s1_axi_awprot(s1_axi_awprot), .s1_axi_arprot(s1_axi_arprot), .s1_axi_awburst(s1_axi_awburst), .s1_axi_arburst(s1_axi_arburst),
      .s1_axi_awlock(s1_axi_awlock), .s1_axi_arlock(s1_axi_arlock), .s1_axi_awcache(s1_axi_awcache), .s1_axi_arcache(s1_axi_arcache),
      .s1_axi_awqos(s1_axi_awqos), .s1_axi_arqos(s1_axi_arqos), .s1_axi_awregion(s1_axi_awregion), .s1_axi_arregion(s1_axi_arregion),
      .s1_axi_awvalid(s1_axi_awvalid), .s1_axi_arvalid(s1_axi_arvalid), .s1_axi_awready(s1_axi_awready), .s1_axi_arready(s1_axi_arready),
      .s1_axi_wdata(s1_axi_wdata), .s1_axi_wstrb(s1_axi_wstrb), .s1_axi_wlast(s1_axi_wlast), .s1_axi_wvalid(s1_axi_wvalid),
      .s1_axi_wready(s1_axi_wready), .s1_axi_bid(s1_axi_bid), .s1_axi_rid(s1_axi_rid), .s1_axi_bresp(s1_axi_bresp),
      .s1_axi_rresp(s1_axi_rresp), .s1_axi_bvalid(s1_axi_bvalid), .s1_axi_bready(s1_axi_bready), .s1_axi_rdata(s1_axi_rdata),
      .s1_axi_rlast(s1_axi_rlast), .s1_axi_rvalid(s1_axi_rvalid), .s1_axi_rready(s1_axi_rready),
      .m_axi_awid(m_axi_awid), .m_axi_arid(m_axi_arid), .m_axi_awaddr(m_axi_awaddr), .m_axi_araddr(m_axi_araddr),
      .m_axi_awlen(m_axi_awlen), .m_axi_arlen(m_axi_arlen), .m_axi_awsize(m_axi_awsize), .m_axi_arsize(m_axi_arsize),
      .m_axi_awprot(m_axi_awprot), .m_axi_arprot(m_axi_arprot), .m_axi_awburst(m_axi_awburst), .m_axi_arburst(m_axi_arburst),
      .m_axi_awlock(m_axi_awlock), .m_axi_arlock(m_axi_arlock), .m_axi_awcache(m_axi_awcache), .m_axi_arcache(m_axi_arcache),
      .m_axi_awqos(m_axi_awqos), .m_axi_arqos(m_axi_arqos), .m_axi_awregion(m_axi_awregion), .m_axi_arregion(m_axi_arregion),
      .m_axi_awvalid(m_axi_awvalid), .m_axi_arvalid(m_axi_arvalid), .m_axi_awready(m_axi_awready), .m_axi_arready(m_axi_arready),
      .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb), .m_axi_wlast(m_axi_wlast), .m_axi_wvalid(m_axi_wvalid),
      .m_axi_wready(m_axi_wready), .m_axi_bid(m_axi_bid), .m_axi_rid(m_axi_rid), .m_axi_bresp(m_axi_bresp),
      .m_axi_rresp(m_axi_rresp), .m_axi_bvalid(m_axi_bvalid), .m_axi_bready(m_axi_bready), .m_axi_rdata(m_axi_rdata),
      .m_axi_rlast(m_axi_rlast), .m_axi_rvalid(m_axi_rvalid), .m_axi_rready(m_axi_rready),
      .wr_owner_o(wr_owner_o), .rd_owner_o(rd_owner_o), .wr_busy_o(wr_busy_o), .rd_busy_o(rd_busy_o)
`ifdef SYS_ARB_STATS_EN
     ,.wr_grants0_o(wr_grants0_o), .wr_grants1_o(wr_grants1_o), .rd_grants0_o(rd_grants0_o), .rd_grants1_o(rd_grants1_o)
`endif
   );

   int n_tests = 0;
   int n_fail  = 0;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk_i);
      #1;
   endtask

   // Drive n W beats from requester 'who' (FSM already in W_DATA); ends in W_RESP.
   task automatic wr_beats(input logic who, input int n);
      for (int b = 0; b < n; b++) begin
         if (who) begin
            s1_axi_wvalid = 1'b1; s1_axi_wdata = 32'h1100 + b; s1_axi_wlast = (b == n - 1);
         end else begin
            s0_axi_wvalid = 1'b1; s0_axi_wdata = 32'h0100 + b; s0_axi_wlast = (b == n - 1);
         end
         #1;
         check("w_data", m_axi_wdata, who ? 32'h1100 + b : 32'h0100 + b);
         check("w_last", m_axi_wlast, (b == n - 1));
         check("w_other_rdy", who ? s0_axi_wready : s1_axi_wready, 1'b0);
         step();
      end
      s0_axi_wvalid = 1'b0; s1_axi_wvalid = 1'b0;
   endtask

   // Complete single-beat write from 'who' starting at idle; ends at idle.
   task automatic single_write(input logic who, input logic [31:0] addr);
      if (who) begin s1_axi_awvalid = 1'b1; s1_axi_awaddr = addr; s1_axi_awlen = 8'd0; end
      else     begin s0_axi_awvalid = 1'b1; s0_axi_awaddr = addr; s0_axi_awlen = 8'd0; end
      step();
      check("sw_owner", wr_owner_o, who);
      check("sw_awaddr", m_axi_awaddr, addr);
      step();
      s0_axi_awvalid = 1'b0; s1_axi_awvalid = 1'b0;
      wr_beats(who, 1);
      check("sw_bvalid", who ? s1_axi_bvalid : s0_axi_bvalid, 1'b1);
      step();
      check("sw_idle", wr_busy_o, 1'b0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, tests=%0d", n_tests);
      $fatal(1, "watchdog");
   end

   initial begin
      {s0_axi_awid, s0_axi_arid, s1_axi_awid, s1_axi_arid} = '0;
      {s0_axi_awaddr, s0_axi_araddr, s1_axi_awaddr, s1_axi_araddr} = '0;
      {s0_axi_awlen, s0_axi_arlen, s1_axi_awlen, s1_axi_arlen} = '0;
      {s0_axi_awsize, s0_axi_arsize, s1_axi_awsize, s1_axi_arsize} = '0;
      {s0_axi_awprot, s0_axi_arprot, s1_axi_awprot, s1_axi_arprot} = '0;
      {s0_axi_awburst, s0_axi_arburst, s1_axi_awburst, s1_axi_arburst} = '0;
      {s0_axi_awlock, s0_axi_arlock, s1_axi_awlock, s1_axi_arlock} = '0;
      {s0_axi_awcache, s0_axi_arcache, s1_axi_awcache, s1_axi_arcache} = '0;
      {s0_axi_awqos, s0_axi_arqos, s1_axi_awqos, s1_axi_arqos} = '0;
      {s0_axi_awregion, s0_axi_arregion, s1_axi_awregion, s1_axi_arregion} = '0;
      {s0_axi_awvalid, s0_axi_arvalid, s1_axi_awvalid, s1_axi_arvalid} = '0;
      {s0_axi_wdata, s1_axi_wdata, s0_axi_wlast, s1_axi_wlast, s0_axi_wvalid, s1_axi_wvalid} = '0;
      s0_axi_wstrb = 4'hF; s1_axi_wstrb = 4'hF;
      s0_axi_bready = 1'b1; s1_axi_bready = 1'b1; s0_axi_rready = 1'b1; s1_axi_rready = 1'b1;
      m_axi_awready = 1'b1; m_axi_wready = 1'b1; m_axi_arready = 1'b1;
      m_axi_bvalid = 1'b1; m_axi_bresp = 2'b00; m_axi_bid = 2'd1;
      m_axi_rvalid = 1'b1; m_axi_rlast = 1'b1; m_axi_rresp = 2'b00; m_axi_rid = 2'd2;
      m_axi_rdata = 32'hCAFE_F00D;

      // reset state
      rstn_i = 1'b0;
      #3;
      check("rst_m_awvalid", m_axi_awvalid, 1'b0);
      check("rst_m_arvalid", m_axi_arvalid, 1'b0);
      check("rst_m_wvalid", m_axi_wvalid, 1'b0);
      check("rst_s_bvalid", {s0_axi_bvalid, s1_axi_bvalid, s0_axi_rvalid, s1_axi_rvalid}, 4'b0);
      check("rst_status", {wr_owner_o, rd_owner_o, wr_busy_o, rd_busy_o}, 4'b0);
      repeat (2) @(posedge clk_i);
      #1 rstn_i = 1'b1;
      step();

      // single s0 write
      s0_axi_awvalid = 1'b1; s0_axi_awaddr = 32'h0000_1000; s0_axi_awlen = 8'd0; s0_axi_awid = 2'd1;
      s0_axi_wvalid = 1'b1; s0_axi_wdata = 32'hDEAD_BEEF; s0_axi_wlast = 1'b1;
      #1;
      check("t1_no_early_aw", m_axi_awvalid, 1'b0);
      step();
      check("t1_awvalid", m_axi_awvalid, 1'b1);
      check("t1_awaddr", m_axi_awaddr, 32'h0000_1000);
      check("t1_awid", m_axi_awid, 2'd1);
      check("t1_s0_awready", s0_axi_awready, 1'b1);
      check("t1_s1_awready", s1_axi_awready, 1'b0);
      check("t1_w_blocked", {m_axi_wvalid, s0_axi_wready}, 2'b00);
      check("t1_busy_owner", {wr_busy_o, wr_owner_o}, 2'b10);
      step();
      s0_axi_awvalid = 1'b0;
      #1;
      check("t1_wvalid", m_axi_wvalid, 1'b1);
      check("t1_wdata", m_axi_wdata, 32'hDEAD_BEEF);
      check("t1_s0_wready", s0_axi_wready, 1'b1);
      check("t1_s1_wready", s1_axi_wready, 1'b0);
      step();
      s0_axi_wvalid = 1'b0;
      #1;
      check("t1_s0_bvalid", s0_axi_bvalid, 1'b1);
      check("t1_bresp", s0_axi_bresp, 2'b00);
      check("t1_bid", s0_axi_bid, 2'd1);
      check("t1_s1_bvalid", s1_axi_bvalid, 1'b0);
      check("t1_m_bready", m_axi_bready, 1'b1);
      step();
      check("t1_idle", wr_busy_o, 1'b0);

      // both request a 4-beat write; pointers start from s0 after reset
      rstn_i = 1'b0; #2; rstn_i = 1'b1;
      s0_axi_awvalid = 1'b1; s0_axi_awaddr = 32'h0000_A000; s0_axi_awlen = 8'd3;
      s1_axi_awvalid = 1'b1; s1_axi_awaddr = 32'h0000_B000; s1_axi_awlen = 8'd3;
      s1_axi_wvalid = 1'b1;
      step();
      check("t2_owner0", wr_owner_o, 1'b0);
      check("t2_awaddr0", m_axi_awaddr, 32'h0000_A000);
      check("t2_s1_awready", s1_axi_awready, 1'b0);
      step();
      s0_axi_awvalid = 1'b0;
      wr_beats(1'b0, 4);
      check("t2_s0_bvalid", s0_axi_bvalid, 1'b1);
      check("t2_owner_resp", wr_owner_o, 1'b0);
      step();
      check("t2_turnaround", {wr_busy_o, m_axi_awvalid}, 2'b00);
      step();
      check("t2_owner1", wr_owner_o, 1'b1);
      check("t2_awaddr1", m_axi_awaddr, 32'h0000_B000);
      check("t2_s1_awready1", s1_axi_awready, 1'b1);
      step();
      s1_axi_awvalid = 1'b0;
      wr_beats(1'b1, 4);
      check("t2_s1_bvalid", {s1_axi_bvalid, s0_axi_bvalid}, 2'b10);
      step();

      // s0 8-beat write concurrent with s1 single-beat read
      s0_axi_awvalid = 1'b1; s0_axi_awaddr = 32'h0000_3000; s0_axi_awlen = 8'd7;
      s1_axi_arvalid = 1'b1; s1_axi_araddr = 32'h0000_2000; s1_axi_arlen = 8'd0; s1_axi_arid = 2'd2;
      step();
      check("t3_wr_owner", wr_owner_o, 1'b0);
      check("t3_rd_owner", rd_owner_o, 1'b1);
      check("t3_araddr", m_axi_araddr, 32'h0000_2000);
      check("t3_arready", {s1_axi_arready, s0_axi_arready}, 2'b10);
      step();
      s0_axi_awvalid = 1'b0; s1_axi_arvalid = 1'b0;
      s0_axi_wvalid = 1'b1; s0_axi_wdata = 32'h0100; s0_axi_wlast = 1'b0;
      #1;
      check("t3_rvalid", {s1_axi_rvalid, s0_axi_rvalid}, 2'b10);
      check("t3_rlast", s1_axi_rlast, 1'b1);
      check("t3_rdata", s1_axi_rdata, 32'hCAFE_F00D);
      check("t3_rid", s1_axi_rid, 2'd2);
      check("t3_w_streaming", m_axi_wvalid, 1'b1);
      wr_beats(1'b0, 8);
      check("t3_rd_done", rd_busy_o, 1'b0);
      check("t3_wr_resp", s0_axi_bvalid, 1'b1);
      step();

      // continuous reads from both: six grants alternating 0,1,0,1,0,1
      s0_axi_arvalid = 1'b1; s0_axi_araddr = 32'h0000_6000;
      s1_axi_arvalid = 1'b1; s1_axi_araddr = 32'h0000_7000;
      for (int k = 0; k < 6; k++) begin
         step();
         check("t4_rd_owner", rd_owner_o, (k % 2 == 1));
         check("t4_araddr", m_axi_araddr, (k % 2 == 1) ? 32'h0000_7000 : 32'h0000_6000);
         step();
         check("t4_rready", m_axi_rready, 1'b1);
         step();
      end
      s0_axi_arvalid = 1'b0; s1_axi_arvalid = 1'b0;

      // asynchronous reset during beat 2 of an s0 burst
      s0_axi_awvalid = 1'b1; s0_axi_awaddr = 32'h0000_4000; s0_axi_awlen = 8'd3;
      step();
      step();
      s0_axi_awvalid = 1'b0;
      s0_axi_wvalid = 1'b1; s0_axi_wlast = 1'b0;
      step();
      step();
      #1;
      check("t5_pre_rst_wvalid", m_axi_wvalid, 1'b1);
      rstn_i = 1'b0;
      #1;
      check("t5_rst_wvalid", m_axi_wvalid, 1'b0);
      check("t5_rst_wready", s0_axi_wready, 1'b0);
      check("t5_rst_awvalid", m_axi_awvalid, 1'b0);
      check("t5_rst_busy", wr_busy_o, 1'b0);
      rstn_i = 1'b1;
      s0_axi_wvalid = 1'b0;
      single_write(1'b1, 32'h0000_5000);

`ifdef SYS_ARB_STATS_EN
      rstn_i = 1'b0; #2; rstn_i = 1'b1;
      check("t6_rst_cnt", {wr_grants0_o, wr_grants1_o, rd_grants0_o, rd_grants1_o}, 64'd0);
      for (int k = 0; k < 5; k++) single_write(1'b0, 32'h0000_8000 + 32'(k * 4));
      for (int k = 0; k < 3; k++) begin
         s1_axi_arvalid = 1'b1; s1_axi_araddr = 32'h0000_9000;
         step();
         step();
         s1_axi_arvalid = 1'b0;
         step();
      end
      check("t6_wr_grants0", wr_grants0_o, 32'd5);
      check("t6_wr_grants1", wr_grants1_o, 32'd0);
      check("t6_rd_grants0", rd_grants0_o, 32'd0);
      check("t6_rd_grants1", rd_grants1_o, 32'd3);
`endif

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
